// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: operand source select
// and flush counter sizing.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // FLUSH_CYCLES tops out at 7, so the reload value never needs more than 3 bits.
    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard unit's performance counters.
// Clear is synchronous and wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// stall-only interlocks, multi-cycle redirect flush, and stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FWD_EN       = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_reg_write,
    input  logic              i_ex_is_load,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    input  logic              i_redirect,
    input  logic              i_mem_busy,
    input  logic              i_perf_clear,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_idex_bubble,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output logic [CNT_W-1:0]  o_flush_events
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    function automatic logic match(input logic [REG_AW-1:0] s,
                                   input logic [REG_AW-1:0] rd,
                                   input logic              we);
        return we && (rd != '0) && (s == rd);
    endfunction

    logic [1:0][REG_AW-1:0] ex_rs;
    logic [1:0][1:0]        fwd_sel;

    assign ex_rs = {i_ex_rs2, i_ex_rs1};

    // MEM holds the younger result, so it is checked before WB.
    for (genvar k = 0; k < 2; k++) begin : g_fwd
        assign fwd_sel[k] = (FWD_EN == 0)                              ? FWD_RF  :
                            match(ex_rs[k], i_mem_rd, i_mem_reg_write) ? FWD_MEM :
                            match(ex_rs[k], i_wb_rd,  i_wb_reg_write)  ? FWD_WB  :
                                                                         FWD_RF;
    end

    assign o_fwd_a = fwd_sel[0];
    assign o_fwd_b = fwd_sel[1];

    logic ex_hit, mem_hit, hazard;

    assign ex_hit  = (i_id_rs1_used && match(i_id_rs1, i_ex_rd, i_ex_reg_write)) ||
                     (i_id_rs2_used && match(i_id_rs2, i_ex_rd, i_ex_reg_write));
    assign mem_hit = (i_id_rs1_used && match(i_id_rs1, i_mem_rd, i_mem_reg_write)) ||
                     (i_id_rs2_used && match(i_id_rs2, i_mem_rd, i_mem_reg_write));
    // Write-before-read regfile: a WB producer never needs an interlock.
    assign hazard  = (i_ex_is_load && ex_hit) || ((FWD_EN == 0) && (ex_hit || mem_hit));

    logic [FLUSH_CNT_W-1:0] flush_cnt;

    // A memory wait freezes the flush sequence; it resumes once busy drops.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            flush_cnt <= '0;
        else if (!i_mem_busy) begin
            if (i_redirect)
                flush_cnt <= FLUSH_RELOAD;
            else if (flush_cnt != '0)
                flush_cnt <= flush_cnt - FLUSH_CNT_W'(1);
        end
    end

    assign o_flush       = i_reset_n && !i_mem_busy && (i_redirect || (flush_cnt != '0));
    assign o_stall       = i_mem_busy || (hazard && !o_flush);
    assign o_pc_write    = !o_stall || (o_flush && !i_mem_busy);
    assign o_ifid_write  = !o_stall;
    assign o_idex_bubble = (o_stall && !i_mem_busy) || o_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .gclk   (i_clk),
        .grst_n (i_reset_n),
        .inc    (o_stall),
        .clr    (i_perf_clear),
        .count  (o_stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .gclk   (i_clk),
        .grst_n (i_reset_n),
        .inc    (i_redirect && !i_mem_busy),
        .clr    (i_perf_clear),
        .count  (o_flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: instance A forwards (3-cycle flush, 4-bit counters),
// instance B is stall-only with default parameters; both see the same inputs.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic [4:0] i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
    logic       i_id_rs1_used, i_id_rs2_used, i_ex_reg_write, i_ex_is_load;
    logic       i_mem_reg_write, i_wb_reg_write, i_redirect, i_mem_busy, i_perf_clear;

    logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
    logic        a_stall, a_flush, a_pcw, a_ifid, a_bub;
    logic        b_stall, b_flush, b_pcw, b_ifid, b_bub;
    logic [3:0]  a_sc, a_fe;
    logic [31:0] b_sc, b_fe;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1), .FLUSH_CYCLES(3), .CNT_W(4)) dut_a (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2), .i_ex_rd(i_ex_rd),
        .i_ex_reg_write(i_ex_reg_write), .i_ex_is_load(i_ex_is_load),
        .i_mem_rd(i_mem_rd), .i_mem_reg_write(i_mem_reg_write),
        .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write),
        .i_redirect(i_redirect), .i_mem_busy(i_mem_busy), .i_perf_clear(i_perf_clear),
        .o_fwd_a(a_fwd_a), .o_fwd_b(a_fwd_b), .o_stall(a_stall), .o_flush(a_flush),
        .o_pc_write(a_pcw), .o_ifid_write(a_ifid), .o_idex_bubble(a_bub),
        .o_stall_cycles(a_sc), .o_flush_events(a_fe)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(0), .FLUSH_CYCLES(1), .CNT_W(32)) dut_b (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
        .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
        .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2), .i_ex_rd(i_ex_rd),
        .i_ex_reg_write(i_ex_reg_write), .i_ex_is_load(i_ex_is_load),
        .i_mem_rd(i_mem_rd), .i_mem_reg_write(i_mem_reg_write),
        .i_wb_rd(i_wb_rd), .i_wb_reg_write(i_wb_reg_write),
        .i_redirect(i_redirect), .i_mem_busy(i_mem_busy), .i_perf_clear(i_perf_clear),
        .o_fwd_a(b_fwd_a), .o_fwd_b(b_fwd_b), .o_stall(b_stall), .o_flush(b_flush),
        .o_pc_write(b_pcw), .o_ifid_write(b_ifid), .o_idex_bubble(b_bub),
        .o_stall_cycles(b_sc), .o_flush_events(b_fe)
    );

    localparam int FWDA_A = 0, FWDB_A = 1, FWDA_B = 2, STALL_A = 3, STALL_B = 4;
    localparam int FLUSH_A = 5, FLUSH_B = 6, PCW_A = 7, IFID_A = 8, BUB_A = 9;
    localparam int SC_A = 10, FE_A = 11, SC_B = 12;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   cur_cyc = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [31:0] actual(input int s);
        case (s)
            FWDA_A:  return 32'(a_fwd_a);
            FWDB_A:  return 32'(a_fwd_b);
            FWDA_B:  return 32'(b_fwd_a);
            STALL_A: return 32'(a_stall);
            STALL_B: return 32'(b_stall);
            FLUSH_A: return 32'(a_flush);
            FLUSH_B: return 32'(b_flush);
            PCW_A:   return 32'(a_pcw);
            IFID_A:  return 32'(a_ifid);
            BUB_A:   return 32'(a_bub);
            SC_A:    return 32'(a_sc);
            FE_A:    return 32'(a_fe);
            SC_B:    return b_sc;
            default: return 32'hdead_beef;
        endcase
    endfunction

    always @(posedge clk) cur_cyc++;

    // Monitor: every record targets the cycle in which it was issued.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cur_cyc) begin
            e   = q.pop_front();
            act = actual(e.sel);
            n_total++;
            if (e.cyc == cur_cyc && act === e.val)
                n_pass++;
            else
                $display("FAIL %s cyc=%0d actual=%0d expected=%0d", e.nm, e.cyc, act, e.val);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd} = '0;
        {i_id_rs1_used, i_id_rs2_used, i_ex_reg_write, i_ex_is_load} = '0;
        {i_mem_reg_write, i_wb_reg_write, i_redirect, i_mem_busy, i_perf_clear} = '0;
    endtask

    task automatic chk(input string nm, input int s, input logic [31:0] v);
        q.push_back('{cyc: cur_cyc, nm: nm, sel: s, val: v});
    endtask

    task automatic load_use_x7(input logic used);
        i_ex_rd = 5'd7; i_ex_reg_write = 1'b1; i_ex_is_load = 1'b1;
        i_id_rs2 = 5'd7; i_id_rs2_used = used;
    endtask

    initial begin
        i_reset_n = 1'b0;
        clr_in();

        // Reset: flush suppressed even with a redirect present
        step(); i_redirect = 1'b1;
        chk("rst_flush_a", FLUSH_A, 0); chk("rst_flush_b", FLUSH_B, 0);
        chk("rst_sc_a", SC_A, 0); chk("rst_fe_a", FE_A, 0); chk("rst_pcw_a", PCW_A, 1);
        step(); clr_in(); i_reset_n = 1'b1;
        chk("idle_stall_a", STALL_A, 0); chk("idle_flush_a", FLUSH_A, 0);

        // Forwarding
        step(); i_mem_rd = 5'd5; i_mem_reg_write = 1'b1; i_ex_rs1 = 5'd5;
        i_ex_rs2 = 5'd6; i_wb_rd = 5'd6; i_wb_reg_write = 1'b1;
        chk("fwd_a_mem", FWDA_A, 1); chk("fwd_b_wb", FWDB_A, 2); chk("fwd_off_b", FWDA_B, 0);
        step(); i_wb_rd = 5'd5;
        chk("fwd_a_mem_over_wb", FWDA_A, 1); chk("fwd_b_none", FWDB_A, 0);
        step(); i_mem_reg_write = 1'b0;
        chk("fwd_a_wb_only", FWDA_A, 2);
        step(); clr_in(); i_mem_reg_write = 1'b1; i_wb_reg_write = 1'b1;
        chk("fwd_a_x0", FWDA_A, 0);

        // Load-use
        step(); clr_in(); load_use_x7(1'b1);
        chk("lu_stall_a", STALL_A, 1); chk("lu_pcw_a", PCW_A, 0); chk("lu_ifid_a", IFID_A, 0);
        chk("lu_bub_a", BUB_A, 1); chk("lu_stall_b", STALL_B, 1);
        step(); clr_in();
        chk("lu_after_stall", STALL_A, 0); chk("lu_after_pcw", PCW_A, 1);
        chk("lu_after_bub", BUB_A, 0); chk("lu_sc_a", SC_A, 1);
        step(); load_use_x7(1'b0);
        chk("lu_unused_a", STALL_A, 0); chk("lu_unused_b", STALL_B, 0);

        // Stall-only interlocks
        step(); clr_in(); i_mem_rd = 5'd3; i_mem_reg_write = 1'b1; i_id_rs1 = 5'd3; i_id_rs1_used = 1'b1;
        chk("so_mem_b", STALL_B, 1); chk("so_mem_a", STALL_A, 0);
        step(); clr_in(); i_wb_rd = 5'd3; i_wb_reg_write = 1'b1; i_id_rs1 = 5'd3; i_id_rs1_used = 1'b1;
        chk("so_wb_b", STALL_B, 0); chk("so_sc_b", SC_B, 2);
        step(); clr_in(); i_ex_rd = 5'd4; i_ex_reg_write = 1'b1; i_id_rs1 = 5'd4; i_id_rs1_used = 1'b1;
        chk("so_ex_b", STALL_B, 1); chk("so_ex_a", STALL_A, 0);

        // Back-to-back redirects
        step(); clr_in(); i_redirect = 1'b1;
        chk("fl_t_a", FLUSH_A, 1); chk("fl_t_b", FLUSH_B, 1); chk("fl_pcw", PCW_A, 1); chk("fl_bub", BUB_A, 1);
        step();
        chk("fl_t1_a", FLUSH_A, 1);
        step(); clr_in(); load_use_x7(1'b1);
        chk("fl_t2_a", FLUSH_A, 1); chk("fl_hide_stall", STALL_A, 0); chk("fl_t2_pcw", PCW_A, 1);
        chk("fl_t2_bub", BUB_A, 1); chk("fl_t2_b", FLUSH_B, 0); chk("fl_t2_stall_b", STALL_B, 1);
        step(); clr_in();
        chk("fl_t3_a", FLUSH_A, 1);
        step();
        chk("fl_t4_a", FLUSH_A, 0); chk("fl_events", FE_A, 2); chk("fl_sc_a", SC_A, 1);

        // Memory wait inside a flush
        step(); i_redirect = 1'b1;
        chk("bz_t", FLUSH_A, 1);
        step(); clr_in(); i_mem_busy = 1'b1;
        chk("bz_flush", FLUSH_A, 0); chk("bz_stall", STALL_A, 1); chk("bz_pcw", PCW_A, 0);
        chk("bz_ifid", IFID_A, 0); chk("bz_bub", BUB_A, 0);
        step(); clr_in();
        chk("bz_resume1", FLUSH_A, 1); chk("bz_resume_stall", STALL_A, 0);
        step();
        chk("bz_resume2", FLUSH_A, 1);
        step();
        chk("bz_done", FLUSH_A, 0); chk("bz_events", FE_A, 3); chk("bz_sc", SC_A, 2);

        // Reset mid-flush
        step(); i_redirect = 1'b1;
        chk("rf_t", FLUSH_A, 1);
        step(); clr_in(); i_reset_n = 1'b0;
        chk("rf_flush", FLUSH_A, 0); chk("rf_sc", SC_A, 0); chk("rf_fe", FE_A, 0); chk("rf_sc_b", SC_B, 0);
        step(); i_reset_n = 1'b1;
        chk("rf_no_tail", FLUSH_A, 0); chk("rf_no_bub", BUB_A, 0);

        // Saturation and clear priority
        for (int i = 0; i < 20; i++) begin
            step(); clr_in(); i_mem_busy = 1'b1;
            chk("sat_sc", SC_A, 32'((i > 15) ? 15 : i));
        end
        step(); i_perf_clear = 1'b1;
        chk("sat_hold", SC_A, 15);
        step(); clr_in();
        chk("clr_sc", SC_A, 0); chk("clr_fe", FE_A, 0);

        step(); step();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d expected=0", q.size());
            n_total++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REG_AW (default 5, register address width); FWD_EN (default 1; 1 = forwarding, 0 = stall-only); FLUSH_CYCLES (default 1, range 1..7, flush length per redirect); CNT_W (default 32, perf counter width).
REQ-002 Clock and reset ports SHALL be: i_clk, in, 1, clock; i_reset_n, in, 1, asynchronous active-low reset.
REQ-003 Inputs SHALL be: i_id_rs1/i_id_rs2, in, REG_AW, ID sources; i_id_rs1_used/i_id_rs2_used, in, 1, source valid.
REQ-004 Inputs SHALL be: i_ex_rs1/i_ex_rs2, in, REG_AW, EX sources; i_ex_rd, in, REG_AW; i_ex_reg_write, in, 1; i_ex_is_load, in, 1.
REQ-005 Inputs SHALL be: i_mem_rd, in, REG_AW; i_mem_reg_write, in, 1; i_wb_rd, in, REG_AW; i_wb_reg_write, in, 1.
REQ-006 Inputs SHALL be: i_redirect, in, 1, branch/jump taken in EX; i_mem_busy, in, 1, memory wait; i_perf_clear, in, 1, synchronous counter clear.
REQ-007 Outputs SHALL be: o_fwd_a/o_fwd_b, out, 2, operand source (00 regfile, 01 MEM, 10 WB); o_stall, out, 1; o_flush, out, 1; o_pc_write, out, 1; o_ifid_write, out, 1; o_idex_bubble, out, 1.
REQ-008 Outputs SHALL be: o_stall_cycles, out, CNT_W; o_flush_events, out, CNT_W.

Function
REQ-009 "Match(s, rd, we)" SHALL mean: we=1, rd!=0, s==rd; rs match also requires the corresponding *_used=1.
REQ-010 FWD_EN=1: o_fwd_a SHALL be 01 on Match(ex_rs1, mem_rd, mem_reg_write); otherwise 10 on Match(ex_rs1, wb_rd, wb_reg_write); otherwise 00. MEM wins over WB. o_fwd_b is identical on ex_rs2.
REQ-011 FWD_EN=0: o_fwd_a and o_fwd_b SHALL be constant 00.
REQ-012 Load-use hazard: i_ex_is_load and Match of either ID source against EX rd SHALL raise the hazard in both modes.
REQ-013 FWD_EN=0: Match of either ID source against EX rd or MEM rd SHALL also raise the hazard. The register file is write-before-read, so WB never stalls.
REQ-014 o_stall SHALL be combinational: (hazard or i_mem_busy) and not o_flush. The exception is i_mem_busy=1, which forces o_stall=1 regardless of flush.
REQ-015 o_flush SHALL be high in the cycle i_redirect=1 (combinational).
REQ-016 o_flush SHALL then stay high for FLUSH_CYCLES-1 further cycles, driven by a registered down-counter.
REQ-017 A redirect during an active flush SHALL reload the counter to FLUSH_CYCLES-1.
REQ-018 While i_mem_busy=1, the flush counter SHALL hold and o_flush SHALL be forced 0. The pending flush resumes when busy drops.
REQ-019 Write enables: o_pc_write SHALL equal not o_stall, except that o_pc_write=1 when o_flush=1 and i_mem_busy=0.
REQ-020 o_ifid_write SHALL equal not o_stall.
REQ-021 o_idex_bubble SHALL equal (o_stall and not i_mem_busy) or o_flush.
REQ-022 o_stall_cycles SHALL increment by 1 on each cycle with o_stall=1.
REQ-023 o_flush_events SHALL increment by 1 on each cycle where i_redirect=1 and i_mem_busy=0.
REQ-024 Both counters SHALL saturate at all-ones.
REQ-025 i_perf_clear SHALL zero both counters on the next edge and take priority over increment.

Reset
REQ-026 While i_reset_n=0: flush counter=0; both perf counters=0; o_flush=0. Combinational outputs follow their inputs.
REQ-027 Reset asserted mid-flush or mid-stall SHALL abort the flush immediately. No flush cycles SHALL remain after release.

Structure
REQ-028 The fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB) SHALL live in the shared definitions package, with the type-enum headers.
REQ-029 The saturating perf counter SHALL be one sub-module, sat_counter (parameter W; ports inc, clr), instantiated twice.
REQ-030 The block SHALL replace the existing hazard detection unit in the pipelined core top level.

Verification
REQ-031 FWD_EN=1, add x5 in MEM, EX rs1=5 -> o_fwd_a=01. Same with x5 in both MEM and WB -> o_fwd_a=01. With rd=x0 -> 00.
REQ-032 FWD_EN=1, lw x7 in EX, ID rs2=7 with rs2_used=1 -> o_stall=1, o_pc_write=0, o_idex_bubble=1 for exactly 1 cycle.
REQ-033 Same stimulus as REQ-032 with rs2_used=0 -> no stall.
REQ-034 FWD_EN=0, x3 written in MEM, ID rs1=3 -> o_stall=1. Same with x3 only in WB -> o_stall=0.
REQ-035 FLUSH_CYCLES=3, i_redirect pulse at cycle t -> o_flush high t..t+2. A second redirect at t+1 -> o_flush high through t+3. o_flush_events=2.
REQ-036 i_mem_busy at t+1 during a 3-cycle flush -> o_flush=0 and o_stall=1 while busy, remaining flush cycles completed afterwards.
REQ-037 i_reset_n low mid-flush -> o_flush=0 and counters=0 immediately.
REQ-038 CNT_W=4 with 20 stall cycles -> o_stall_cycles=15 (saturated). i_perf_clear -> 0 next cycle.
